// File: rtl/i_alu_arbiter_pkg.sv
// Types, constants and encoding helpers shared by the OP-IMM ALU arbiter.
package i_alu_arbiter_pkg;

  typedef enum logic [2:0] {
    ADDI  = 3'b000,
    SLLI  = 3'b001,
    SLTI  = 3'b010,
    SLTIU = 3'b011,
    XORI  = 3'b100,
    SRXI  = 3'b101,
    ORI   = 3'b110,
    ANDI  = 3'b111
  } i_func;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE = 1'b0;
  localparam arb_state_t EXEC = 1'b1;

  localparam logic [6:0] SHAMT_HI_LOGICAL = 7'b0000000;
  localparam logic [6:0] SHAMT_HI_ARITH   = 7'b0100000;

  // Shift immediates must carry an all-zero upper field (or 0100000 for SRAI).
  function automatic logic shamt_illegal(input logic [2:0] funct3, input logic [11:0] imm12);
    logic err;
    case (funct3)
      SLLI:    err = (imm12[11:5] != SHAMT_HI_LOGICAL);
      SRXI:    err = (imm12[11:5] != SHAMT_HI_LOGICAL) && (imm12[11:5] != SHAMT_HI_ARITH);
      default: err = 1'b0;
    endcase
    return err;
  endfunction

  function automatic logic shift_alt(input logic [2:0] funct3, input logic imm10);
    return (funct3 == SRXI) && imm10;
  endfunction

endpackage

// File: rtl/i_alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after last_grant.
module i_alu_arbiter_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         eligible_i,
  input  logic [$clog2(NREQ)-1:0] last_grant_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] grant_idx_o
);
  localparam int IDXW = $clog2(NREQ);

  int              cand_s;
  logic [IDXW-1:0] cand_idx_s;
  logic            found_s;

  // Scan requesters starting one past the previous winner, wrapping modulo NREQ.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found_s     = 1'b0;
    cand_s      = 0;
    cand_idx_s  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand_s     = (int'(last_grant_i) + off) % NREQ;
      cand_idx_s = cand_s[IDXW-1:0];
      if (!found_s && eligible_i[cand_idx_s]) begin
        found_s             = 1'b1;
        grant_o[cand_idx_s] = 1'b1;
        grant_idx_o         = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/i_alu_arbiter.sv
// Shares one external combinational I-type ALU between NREQ requesters,
// with a one-cycle operand stage and a one-entry response buffer per requester.
module i_alu_arbiter
  import i_alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][2:0]       req_funct3,
  input  logic [NREQ-1:0][XLEN-1:0]  req_rv1,
  input  logic [NREQ-1:0][XLEN-1:0]  req_imm,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [NREQ-1:0][XLEN-1:0]  rsp_data,
  output logic [NREQ-1:0]            rsp_err,
  output logic [XLEN-1:0]            alu_idata,
  output logic [XLEN-1:0]            alu_rv1,
  output logic [XLEN-1:0]            alu_imm,
  input  logic [XLEN-1:0]            alu_result
);
  localparam int IDXW = $clog2(NREQ);

  arb_state_t                state_q, state_d;
  logic [IDXW-1:0]           owner_q, owner_d;
  logic [2:0]                f3_q, f3_d;
  logic [XLEN-1:0]           rv1_q, rv1_d;
  logic [XLEN-1:0]           imm_q, imm_d;
  logic                      err_q, err_d;
  logic [IDXW-1:0]           last_q, last_d;
  logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0][XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [NREQ-1:0]           rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]           eligible_s;
  logic [NREQ-1:0]           grant_s;
  logic [IDXW-1:0]           grant_idx_s;
  logic                      hs_s;

  // A full buffer or an operation already in flight blocks that requester.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible_s[i] = req_valid[i] && !rsp_valid_q[i] &&
                      !((state_q == EXEC) && (owner_q == IDXW'(i)));
    end
  end

  i_alu_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .eligible_i   (eligible_s),
    .last_grant_i (last_q),
    .grant_o      (grant_s),
    .grant_idx_o  (grant_idx_s)
  );

  assign req_ready = reset ? grant_s : '0;
  assign hs_s      = reset && (|grant_s);

  // Operand stage: load the winner's operation, otherwise drop back to IDLE.
  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    f3_d    = f3_q;
    rv1_d   = rv1_q;
    imm_d   = imm_q;
    err_d   = err_q;
    last_d  = last_q;
    if (hs_s) begin
      state_d = EXEC;
      owner_d = grant_idx_s;
      f3_d    = req_funct3[grant_idx_s];
      rv1_d   = req_rv1[grant_idx_s];
      imm_d   = req_imm[grant_idx_s];
      err_d   = shamt_illegal(req_funct3[grant_idx_s], req_imm[grant_idx_s][11:0]);
      last_d  = grant_idx_s;
    end else begin
      state_d = IDLE;
    end
  end

  // Response buffers: capture from the ALU for the owner, release on rsp_ready.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_q == EXEC) && (owner_q == IDXW'(i))) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = alu_result;
        rsp_err_d[i]   = err_q;
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end else begin
        rsp_valid_d[i] = rsp_valid_q[i];
      end
    end
  end

  // ALU bus is driven only while an operation is in flight.
  always_comb begin
    alu_idata = '0;
    alu_rv1   = '0;
    alu_imm   = '0;
    if (state_q == EXEC) begin
      alu_idata[14:12] = f3_q;
      alu_idata[30]    = shift_alt(f3_q, imm_q[10]);
      alu_rv1          = rv1_q;
      alu_imm          = imm_q;
    end else begin
      alu_idata = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      f3_q        <= 3'b000;
      rv1_q       <= '0;
      imm_q       <= '0;
      err_q       <= 1'b0;
      last_q      <= IDXW'(NREQ - 1);
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      f3_q        <= f3_d;
      rv1_q       <= rv1_d;
      imm_q       <= imm_d;
      err_q       <= err_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
